// File: rtl/dot_matrix_scan.sv
// Row-scanning driver for the 10x14 dot matrix.
// It draws the tic-tac-toe board as a 3x3 grid of X/O glyphs, and row 9 shows whose turn it is.
module dot_matrix_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [17:0] board,
    input  logic        turn_o,
    input  logic [8:0]  blink_mask,
    output logic [9:0]  dot_row,
    output logic [13:0] dot_col,
    output logic        frame_start
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [3:0]       ROW_MAX = 4'd9;

    logic [DIV_W-1:0] div;
    logic [3:0]       row;
    logic [FRM_W-1:0] frame_cnt;
    logic             blink_phase;
    logic [17:0]      board_snap;
    logic             turn_snap;

    logic [1:0]       cell_row;
    logic [1:0]       glyph_line;
    logic [13:0]      row_pattern;
    logic             frame_begin;
    int               cell_idx;
    logic [1:0]       cell_code;
    logic [3:0]       cell_glyph;

    function automatic logic [3:0] glyph(input logic [1:0] code, input logic [1:0] line);
        logic [3:0] g;
        g = 4'b0000;
        case (code)
            2'b01:   g = (line == 2'd1) ? 4'b0110 : 4'b1001;
            2'b10:   g = (line == 2'd1) ? 4'b1001 : 4'b0110;
            default: g = 4'b0000;
        endcase
        return g;
    endfunction

    assign frame_begin = (div == '0) && (row == 4'd0);

    always_comb begin
        cell_row   = 2'd0;
        glyph_line = 2'd0;
        case (row)
            4'd0: begin cell_row = 2'd0; glyph_line = 2'd0; end
            4'd1: begin cell_row = 2'd0; glyph_line = 2'd1; end
            4'd2: begin cell_row = 2'd0; glyph_line = 2'd2; end
            4'd3: begin cell_row = 2'd1; glyph_line = 2'd0; end
            4'd4: begin cell_row = 2'd1; glyph_line = 2'd1; end
            4'd5: begin cell_row = 2'd1; glyph_line = 2'd2; end
            4'd6: begin cell_row = 2'd2; glyph_line = 2'd0; end
            4'd7: begin cell_row = 2'd2; glyph_line = 2'd1; end
            4'd8: begin cell_row = 2'd2; glyph_line = 2'd2; end
            default: begin cell_row = 2'd0; glyph_line = 2'd0; end
        endcase
    end

    // Pixels come from the frame snapshot, but blink_mask is applied live.
    always_comb begin
        row_pattern = '0;
        cell_idx    = 0;
        cell_code   = 2'b00;
        cell_glyph  = 4'b0000;
        if (row == ROW_MAX) begin
            row_pattern = turn_snap ? 14'h3C00 : 14'h000F;
        end else begin
            row_pattern[4] = 1'b1;
            row_pattern[9] = 1'b1;
            for (int c = 0; c < 3; c++) begin
                cell_idx   = int'(cell_row) * 3 + c;
                cell_code  = board_snap[2*cell_idx +: 2];
                cell_glyph = glyph(cell_code, glyph_line);
                if (blink_mask[cell_idx] && blink_phase) begin
                    cell_glyph = 4'b0000;
                end
                row_pattern[5*c +: 4] = cell_glyph;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div         <= '0;
            row         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            board_snap  <= '0;
            turn_snap   <= 1'b0;
            dot_row     <= '0;
            dot_col     <= '0;
            frame_start <= 1'b0;
        end else if (!enable) begin
            div         <= '0;
            row         <= '0;
            dot_row     <= '0;
            dot_col     <= '0;
            frame_start <= 1'b0;
        end else begin
            dot_row     <= 10'b1 << row;
            // Each row period starts with one blank cycle so the previous row does not ghost.
            dot_col     <= (div == '0) ? 14'h0000 : row_pattern;
            frame_start <= frame_begin;
            if (frame_begin) begin
                board_snap <= board;
                turn_snap  <= turn_o;
            end
            if (div == DIV_MAX) begin
                div <= '0;
                if (row == ROW_MAX) begin
                    row <= '0;
                    if (frame_cnt == FRM_MAX) begin
                        frame_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        frame_cnt <= frame_cnt + FRM_W'(1);
                    end
                end else begin
                    row <= row + 4'd1;
                end
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

endmodule
